// File: rtl/spi_slave_pkg.sv
// Shared state encoding and command codes for the SPI slave front-end.
// Latency: none (declarations only). Backpressure: none.
// Flow control: none.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RX,
        WAIT_TX,
        TX,
        DONE
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Bidirectional-order shift register used as both the rx deserialiser and the tx serialiser.
// Latency: nxt_dat/ser_out are combinational from the current (or loaded) word; state updates on clk.
// Backpressure: none; shifts whenever load or shift_en is high.
module spi_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] load_dat,
    output logic [WIDTH-1:0] nxt_dat,
    output logic             ser_out
);

    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] src;

    // A load shifts once in the same edge, so the first bit can leave immediately.
    assign src = load ? load_dat : dat_q;

    always_comb begin
        if (LSB_FIRST) begin
            nxt_dat = {ser_in, src[WIDTH-1:1]};
            ser_out = src[0];
        end else begin
            nxt_dat = {src[WIDTH-2:0], ser_in};
            ser_out = src[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
        end else if (load || shift_en) begin
            dat_q <= nxt_dat;
        end
    end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave front-end: 2-bit cmd + payload in, read word out on MISO; SPI_SLAVE_BURST_EN enables multi-word frames.
// Latency: rx_valid one cycle after the last payload bit; MISO carries bit 0 the cycle after tx_valid is seen.
// Backpressure: none on rx; tx waits up to TX_TIMEOUT cycles for tx_valid, then pulses tx_timeout.
module spi_slave_burst
    import spi_slave_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter int TX_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [DATA_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [DATA_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 busy,
    output logic                 tx_timeout
);

`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam int CNT_MAX = (DATA_SIZE > TX_TIMEOUT) ? DATA_SIZE : TX_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_SIZE - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TX_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           cmd_q, cmd_d;
    logic                 miso_d;
    logic [DATA_SIZE+1:0] rx_dat_d;
    logic                 rx_vld_d;
    logic                 to_d;
    logic                 rx_shift, tx_load, tx_shift;
    logic [DATA_SIZE-1:0] rx_nxt, tx_nxt_unused;
    logic                 tx_ser, rx_ser_unused;

    spi_shift_reg #(.WIDTH(DATA_SIZE), .LSB_FIRST(LSB_FIRST)) u_rx_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .shift_en (rx_shift),
        .ser_in   (MOSI),
        .load_dat ('0),
        .nxt_dat  (rx_nxt),
        .ser_out  (rx_ser_unused)
    );

    spi_shift_reg #(.WIDTH(DATA_SIZE), .LSB_FIRST(LSB_FIRST)) u_tx_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .shift_en (tx_shift),
        .ser_in   (1'b0),
        .load_dat (tx_data),
        .nxt_dat  (tx_nxt_unused),
        .ser_out  (tx_ser)
    );

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        miso_d   = 1'b0;
        rx_dat_d = rx_data;
        rx_vld_d = 1'b0;
        to_d     = 1'b0;
        rx_shift = 1'b0;
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        if (SS_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: begin
                    cmd_d = {cmd_q[0], MOSI};
                    if (cnt_q == CNT_ONE) begin
                        state_d = RX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RX: begin
                    rx_shift = 1'b1;
                    if (cnt_q == BIT_LAST) begin
                        rx_vld_d = 1'b1;
                        rx_dat_d = {cmd_q, rx_nxt};
                        cnt_d    = '0;
                        case (cmd_q)
                            CMD_RD_DATA: state_d = WAIT_TX;
                            CMD_WR_DATA: state_d = BURST_EN ? RX : DONE;
                            default:     state_d = DONE;
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                WAIT_TX: begin
                    // tx_valid takes priority over an expiry on the same edge.
                    if (tx_valid) begin
                        tx_load = 1'b1;
                        miso_d  = tx_ser;
                        state_d = TX;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        to_d    = 1'b1;
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                TX: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d = '0;
                        if (BURST_EN) begin
                            rx_vld_d = 1'b1;
                            rx_dat_d = {CMD_RD_DATA, {DATA_SIZE{1'b0}}};
                            state_d  = WAIT_TX;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        tx_shift = 1'b1;
                        miso_d   = tx_ser;
                        cnt_d    = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            MISO       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            MISO       <= miso_d;
            rx_data    <= rx_dat_d;
            rx_valid   <= rx_vld_d;
            tx_timeout <= to_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench: an MSB-first and an LSB-first instance share all inputs; outputs checked against hand values.
// Latency: n/a. Backpressure: n/a.
module tb_spi_slave_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic       miso_m, rx_valid_m, busy_m, tx_timeout_m;
    logic [9:0] rx_data_m;
    logic       miso_l, rx_valid_l, busy_l, tx_timeout_l;
    logic [9:0] rx_data_l;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_slave_burst #(.DATA_SIZE(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(16)) u_dut_msb (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (ss_n),
        .MOSI       (mosi),
        .MISO       (miso_m),
        .rx_data    (rx_data_m),
        .rx_valid   (rx_valid_m),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (busy_m),
        .tx_timeout (tx_timeout_m)
    );

    spi_slave_burst #(.DATA_SIZE(8), .LSB_FIRST(1'b1), .TX_TIMEOUT(16)) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (ss_n),
        .MOSI       (mosi),
        .MISO       (miso_l),
        .rx_data    (rx_data_l),
        .rx_valid   (rx_valid_l),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (busy_l),
        .tx_timeout (tx_timeout_l)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] cmd);
        ss_n = 1'b0;
        tick;
        check("busy_in_frame", 16'(busy_m), 16'h1);
        mosi = cmd[1];
        tick;
        mosi = cmd[0];
        tick;
    endtask

    // Wire order is always w[7] first; the LSB-first instance sees it bit-reversed.
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            mosi = w[i];
            tick;
            if (i == 1) check("no_early_vld", 16'(rx_valid_m), 16'h0);
        end
    endtask

    task automatic end_frame;
        ss_n = 1'b1;
        mosi = 1'b0;
        tick;
    endtask

    initial begin
        logic [7:0] pat;

        // Reset
        #2 rst = 1'b1;
        #2;
        check("rst_miso", 16'(miso_m), 16'h0);
        check("rst_rx_valid", 16'(rx_valid_m), 16'h0);
        check("rst_rx_data", 16'(rx_data_m), 16'h000);
        check("rst_busy", 16'(busy_m), 16'h0);
        check("rst_timeout", 16'(tx_timeout_m), 16'h0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        check("idle_busy", 16'(busy_l), 16'h0);

        // Write-address frame 00 + A5
        start_frame(2'b00);
        send_word(8'hA5);
        check("wa_vld_m", 16'(rx_valid_m), 16'h1);
        check("wa_dat_m", 16'(rx_data_m), 16'h0A5);
        check("wa_dat_l", 16'(rx_data_l), 16'h0A5);
        mosi = 1'b1;
        tick;
        check("wa_vld_one_cycle", 16'(rx_valid_m), 16'h0);
        check("wa_done_busy", 16'(busy_m), 16'h1);
        tick;
        check("wa_done_miso", 16'(miso_m), 16'h0);
        end_frame;
        check("wa_idle_busy", 16'(busy_m), 16'h0);

        // Read-data frame, tx_valid on the third WAIT_TX edge
        start_frame(2'b11);
        send_word(8'h00);
        check("rd_dat_m", 16'(rx_data_m), 16'h300);
        tick;
        tick;
        check("rd_wait_miso", 16'(miso_m), 16'h0);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tick;
        tx_valid = 1'b0;
        pat = 8'b0011_1100;
        for (int i = 0; i < 8; i++) begin
            check("rd_miso_m", 16'(miso_m), 16'(pat[7-i]));
            check("rd_miso_l", 16'(miso_l), 16'(pat[i]));
            tick;
        end
        check("rd_after_miso", 16'(miso_m), 16'h0);
        check("rd_after_busy", 16'(busy_m), 16'h1);
        end_frame;

        // Read-address frame: bits 1,0 then 1,0,0,0,0,0,0,0
        start_frame(2'b10);
        send_word(8'h80);
        check("ra_dat_m", 16'(rx_data_m), 16'h280);
        check("ra_dat_l", 16'(rx_data_l), 16'h201);
        end_frame;

        // Read of 8'h01: MSB-first shows it last, LSB-first first
        start_frame(2'b11);
        send_word(8'h00);
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        tick;
        tx_valid = 1'b0;
        pat = 8'h01;
        for (int i = 0; i < 8; i++) begin
            check("r01_miso_m", 16'(miso_m), 16'(pat[7-i]));
            check("r01_miso_l", 16'(miso_l), 16'(pat[i]));
            tick;
        end
        check("r01_after_miso_l", 16'(miso_l), 16'h0);
        end_frame;

        // Timeout with tx_valid held low
        start_frame(2'b11);
        send_word(8'h00);
        for (int i = 0; i < 15; i++) tick;
        check("to_not_yet", 16'(tx_timeout_m), 16'h0);
        tick;
        check("to_pulse_m", 16'(tx_timeout_m), 16'h1);
        check("to_pulse_l", 16'(tx_timeout_l), 16'h1);
        check("to_miso", 16'(miso_m), 16'h0);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick;
        check("to_one_cycle", 16'(tx_timeout_m), 16'h0);
        check("to_done_busy", 16'(busy_m), 16'h1);
        check("done_ignores_txv", 16'(miso_m), 16'h0);
        tx_valid = 1'b0;
        end_frame;

        // tx_valid on the expiry edge wins
        start_frame(2'b11);
        send_word(8'h00);
        for (int i = 0; i < 15; i++) tick;
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        tick;
        tx_valid = 1'b0;
        check("race_no_timeout", 16'(tx_timeout_m), 16'h0);
        check("race_miso_m", 16'(miso_m), 16'h1);
        check("race_miso_l", 16'(miso_l), 16'h1);
        tick;
        check("race_bit1_m", 16'(miso_m), 16'h0);
        end_frame;
        check("abort_tx_miso", 16'(miso_m), 16'h0);
        check("abort_tx_busy", 16'(busy_m), 16'h0);

        // Abort after 5 payload bits, then a clean frame
        start_frame(2'b01);
        mosi = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        end_frame;
        check("abort_no_vld", 16'(rx_valid_m), 16'h0);
        check("abort_busy", 16'(busy_m), 16'h0);
        start_frame(2'b01);
        send_word(8'hFF);
        check("wd_dat_m", 16'(rx_data_m), 16'h1FF);
        check("wd_dat_l", 16'(rx_data_l), 16'h1FF);
        end_frame;

        // Two words in one write-data frame
        start_frame(2'b01);
        send_word(8'h11);
        check("w1_vld", 16'(rx_valid_m), 16'h1);
        check("w1_dat_m", 16'(rx_data_m), 16'h111);
        check("w1_dat_l", 16'(rx_data_l), 16'h188);
        send_word(8'h22);
`ifdef SPI_SLAVE_BURST_EN
        check("w2_vld", 16'(rx_valid_m), 16'h1);
        check("w2_dat_m", 16'(rx_data_m), 16'h122);
        check("w2_dat_l", 16'(rx_data_l), 16'h144);
`else
        check("w2_no_vld", 16'(rx_valid_m), 16'h0);
        check("w2_dat_hold", 16'(rx_data_m), 16'h111);
`endif
        end_frame;

        // Async reset in the middle of TX
        start_frame(2'b11);
        send_word(8'h00);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick;
        tx_valid = 1'b0;
        tick;
        tick;
        check("pre_rst_miso", 16'(miso_m), 16'h1);
        rst = 1'b1;
        #1;
        check("arst_miso_m", 16'(miso_m), 16'h0);
        check("arst_miso_l", 16'(miso_l), 16'h0);
        check("arst_busy", 16'(busy_m), 16'h0);
        ss_n = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        check("post_rst_busy", 16'(busy_m), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
- Parametrised next-generation SPI slave front-end for the single-port RAM wrapper.
- Deserialises a 2-bit command plus a DATA_SIZE-bit payload from MOSI and presents {cmd, payload} on rx_data with a one-cycle rx_valid strobe.
- For read-data commands, waits a bounded time for tx_valid, then serialises tx_data on MISO.
- Adds over the previous generation: configurable width, configurable bit order, tx wait timeout, and an optional multi-word burst.

Parameters:
- DATA_SIZE, 8, payload width in bits (>=2).
- LSB_FIRST, 0, 0: MSB shifted first on MOSI and MISO; 1: LSB first.
- TX_TIMEOUT, 16, maximum cycles spent in WAIT_TX before abort (>=1).

Ports:
- clk  in  1  SPI clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- SS_n  in  1  active-low slave select; a frame is one low period.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out.
- rx_data  out  DATA_SIZE+2  {cmd[1:0], payload}; registered.
- rx_valid  out  1  one-cycle strobe; rx_data valid while high.
- tx_data  in  DATA_SIZE  read word from RAM.
- tx_valid  in  1  tx_data valid; sampled only in WAIT_TX.
- busy  out  1  high in any state other than IDLE.
- tx_timeout  out  1  one-cycle pulse when WAIT_TX expires.

Behaviour:
- Reset (rst=1, async): state=IDLE; MISO, rx_valid, tx_timeout, busy = 0; rx_data = 0; all counters and shift registers cleared.
- States: IDLE, CMD, RX, WAIT_TX, TX, DONE.
- IDLE: SS_n=0 at posedge -> CMD. That edge samples no bit.
- CMD: samples 2 bits, first bit = cmd[1]. After the 2nd bit -> RX.
- RX: samples DATA_SIZE bits into the shift register in the order set by LSB_FIRST. On the edge sampling the last bit, rx_data <= {cmd, word} and rx_valid=1 for exactly the following cycle.
  - cmd 00 (write addr), 01 (write data), 10 (read addr): -> DONE.
  - cmd 11 (read data): -> WAIT_TX.
- WAIT_TX: MISO=0. A cycle counter starts at 0.
  - tx_valid=1 at an edge -> tx_data loaded into the tx shift register -> TX.
  - Counter reaches TX_TIMEOUT-1 with tx_valid=0 -> tx_timeout=1 for one cycle -> DONE.
  - If tx_valid and expiry coincide, tx_valid wins; no timeout pulse.
- TX: MISO is registered and carries bit 0..DATA_SIZE-1 on the DATA_SIZE cycles immediately after the load edge. MOSI is ignored. After the last bit -> DONE; MISO=0 from the next cycle.
- DONE: all inputs ignored and MISO=0 until SS_n=1.
- SS_n=1 in any state: -> IDLE at that edge. MISO=0 and rx_valid=0 from the next cycle. A partial word is discarded with no rx_valid. A pending timeout is cancelled with no pulse.
- Changes to tx_valid outside WAIT_TX have no effect.
- Frame latency: rx_valid rises DATA_SIZE+3 edges after the first SS_n=0 edge.

Optional Feature:
- Macro: SPI_SLAVE_BURST_EN.
- Defined:
  - cmd 01: after each word, stays in RX and receives the next word. Each word produces its own rx_valid with cmd=01, continuing until SS_n=1.
  - cmd 11: after TX completes, rx_valid pulses with {2'b11, all zeros} (next-word request) and the FSM re-enters WAIT_TX with a fresh timeout.
- Undefined: single word per frame as described above; the behaviour is identical.

Decomposition:
- Package spi_slave_pkg holds:
  - state enum (IDLE, CMD, RX, WAIT_TX, TX, DONE);
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- Sub-module spi_shift_reg (parametrised width and direction) is used twice: rx deserialiser and tx serialiser.

Test Plan:
- DATA_SIZE=8, MSB-first frame 00 + 8'hA5 -> rx_valid for one cycle with rx_data=10'h0A5 at edge 11; then DONE, MISO stays 0.
- Frame 11 + 8'h00, tx_valid 3 cycles later with tx_data=8'h3C -> rx_data=10'h300; MISO sequence 0,0,1,1,1,1,0,0 on the 8 cycles after load.
- LSB_FIRST=1, frame 10 + bits 1,0,0,0,0,0,0,0 -> rx_data=10'h201; read of 8'h01 outputs MISO 1 first.
- Frame 11 with tx_valid held 0 and TX_TIMEOUT=16 -> tx_timeout pulses once, 16 cycles after WAIT_TX entry; MISO remains 0.
- SS_n raised after 5 payload bits -> no rx_valid; IDLE and busy=0 next cycle. A following frame 01 + 8'hFF decodes correctly to 10'h1FF.
- rst asserted mid-TX -> MISO=0 and busy=0 immediately (async). With SPI_SLAVE_BURST_EN, frame 01 + 8'h11 + 8'h22 -> two rx_valid pulses: 10'h111 then 10'h122.
